// File: rtl/muldiv_sequencer.sv
// Multi-cycle M-extension unit: shift-add multiply and restoring divide.
// The EX stage is stalled while an operation iterates; RESULT is presented
// with a single-cycle DONE pulse and then held until the next operation completes.
module muldiv_sequencer #(
    parameter int ITER_PER_CYCLE = 1    // 1 or 2 iteration steps per clock
) (
    input  logic        CLK,
    input  logic        RESET,           // asynchronous, active low
    input  logic        VALID,
    input  logic [4:0]  ALUOP,
    input  logic [31:0] OPERAND1,
    input  logic [31:0] OPERAND2,
    input  logic        FLUSH,
    output logic        STALL,
    output logic        DONE,
    output logic [31:0] RESULT
);

    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_DIVU   = 5'b10000;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;

    // Counter value seen during the final BUSY cycle.
    localparam logic [5:0] LAST_COUNT = 6'(32 - ITER_PER_CYCLE);
    localparam logic [5:0] COUNT_STEP = 6'(ITER_PER_CYCLE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  op_q, op_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;   // negate product / quotient at the end
    logic        neg_rem_q, neg_rem_d;   // negate remainder (dividend was negative)
    logic [31:0] addend_q, addend_d;     // multiplicand or divisor magnitude
    logic [31:0] hi_q, hi_d;             // product high half / partial remainder
    logic [31:0] lo_q, lo_d;             // multiplier / dividend-quotient shifter
    logic [5:0]  count_q, count_d;
    logic [31:0] result_q, result_d;

    // Decode of the incoming instruction
    logic        is_mop;
    logic        in_div;
    logic        in_rem;
    logic        op1_signed;
    logic        op2_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] bypass_val;
    logic        accept;

    // Iteration datapath outputs
    logic [31:0] hi_n;
    logic [31:0] lo_n;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] final_val;

    // One iteration step. Multiply: conditionally add the multiplicand into the
    // high half, then shift {carry,hi,lo} right. Divide: shift the next dividend
    // bit into the partial remainder and subtract the divisor when it fits.
    function automatic logic [63:0] step(input logic        div_mode,
                                         input logic [31:0] hi,
                                         input logic [31:0] lo,
                                         input logic [31:0] addend);
        logic [32:0] sum;
        logic [32:0] shifted;
        logic        ge;
        logic [31:0] new_hi;
        logic [63:0] r;
        sum     = {1'b0, hi} + {1'b0, addend};
        shifted = {hi, lo[31]};
        ge      = (shifted >= {1'b0, addend});
        new_hi  = ge ? (shifted[31:0] - addend) : shifted[31:0];
        if (div_mode) begin
            r = {new_hi, lo[30:0], ge};
        end else begin
            if (!lo[0]) begin
                sum = {1'b0, hi};
            end
            r = {sum[32:1], sum[0], lo[31:1]};
        end
        return r;
    endfunction

    // Classify the EX-stage opcode and form operand magnitudes and bypass results
    always_comb begin
        is_mop     = ALUOP inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                                   OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        in_div     = ALUOP inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        in_rem     = ALUOP inside {OP_REM, OP_REMU};
        op1_signed = ALUOP inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        op2_signed = ALUOP inside {OP_MULH, OP_DIV, OP_REM};
        a_neg      = op1_signed & OPERAND1[31];
        b_neg      = op2_signed & OPERAND2[31];
        a_mag      = a_neg ? (~OPERAND1 + 32'd1) : OPERAND1;
        b_mag      = b_neg ? (~OPERAND2 + 32'd1) : OPERAND2;
        div_zero   = in_div & (OPERAND2 == 32'd0);
        div_ovf    = ((ALUOP == OP_DIV) | (ALUOP == OP_REM)) &
                     (OPERAND1 == 32'h8000_0000) & (OPERAND2 == 32'hFFFF_FFFF);
        bypass_val = 32'd0;
        if (div_zero) begin
            bypass_val = in_rem ? OPERAND1 : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            bypass_val = in_rem ? 32'd0 : 32'h8000_0000;
        end
        accept     = VALID & is_mop & ~FLUSH;
    end

    // Run ITER_PER_CYCLE steps and apply the sign fix-up to the last step's result
    always_comb begin
        logic [63:0] s;
        logic [63:0] prod;
        s = {hi_q, lo_q};
        for (int i = 0; i < ITER_PER_CYCLE; i++) begin
            s = step(is_div_q, s[63:32], s[31:0], addend_q);
        end
        hi_n      = s[63:32];
        lo_n      = s[31:0];
        prod      = s;
        prod_fix  = neg_res_q ? (~prod + 64'd1) : prod;
        quot_fix  = neg_res_q ? (~lo_n + 32'd1) : lo_n;
        rem_fix   = neg_rem_q ? (~hi_n + 32'd1) : hi_n;
        final_val = 32'd0;
        case (op_q)
            OP_MUL:                       final_val = prod_fix[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_val = prod_fix[63:32];
            OP_DIV, OP_DIVU:              final_val = quot_fix;
            OP_REM, OP_REMU:              final_val = rem_fix;
            default:                      final_val = 32'd0;
        endcase
    end

    // Next-state, datapath load and result capture
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        addend_d  = addend_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        count_d   = count_q;
        result_d  = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d      = ALUOP;
                    count_d   = 6'd0;
                    is_div_d  = in_div;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    hi_d      = 32'd0;
                    lo_d      = in_div ? a_mag : b_mag;
                    addend_d  = in_div ? b_mag : a_mag;
                    if (div_zero | div_ovf) begin
                        state_d  = ST_DONE;
                        result_d = bypass_val;
                    end else begin
                        state_d  = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (FLUSH) begin
                    state_d = ST_IDLE;
                    count_d = 6'd0;
                end else begin
                    hi_d    = hi_n;
                    lo_d    = lo_n;
                    count_d = count_q + COUNT_STEP;
                    if (count_q == LAST_COUNT) begin
                        state_d  = ST_DONE;
                        result_d = final_val;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by RESET
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            op_q      <= 5'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            addend_q  <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            count_q   <= 6'd0;
            result_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            addend_q  <= addend_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            count_q   <= count_d;
            result_q  <= result_d;
        end
    end

    // STALL covers the accept cycle and BUSY; it is forced low while in reset
    always_comb begin
        STALL  = RESET & (((state_q == ST_IDLE) & accept) | (state_q == ST_BUSY));
        DONE   = (state_q == ST_DONE);
        RESULT = result_q;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: ITER_PER_CYCLE, default 1, number of multiply/divide iteration steps per clock; legal values 1 or 2.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 VALID  input  1  EX-stage instruction is valid this cycle.
REQ-005 ALUOP  input  5  decoded ALU opcode from the decoder.
REQ-006 OPERAND1  input  32  rs1 value (multiplicand / dividend).
REQ-007 OPERAND2  input  32  rs2 value (multiplier / divisor).
REQ-008 FLUSH  input  1  pipeline flush; aborts any operation in flight.
REQ-009 STALL  output  1  freezes IF/ID/EX pipeline registers.
REQ-010 DONE  output  1  one-cycle pulse; RESULT is valid.
REQ-011 RESULT  output  32  M-extension result; held until the next accepted operation.

Function
REQ-012 M-op codes SHALL be: MUL 01011, MULH 01100, MULHSU 01101, MULHU 01110, DIV 01111, DIVU 10000, REM 10001, REMU 10010; all other ALUOP values SHALL be ignored.
REQ-013 FSM states SHALL be IDLE, BUSY and DONE.
REQ-014 IDLE->BUSY SHALL occur on an edge with VALID=1, an M-op and FLUSH=0; on that edge the opcode and operands are latched and the iteration counter is cleared.
REQ-015 Operands SHALL be converted to magnitudes according to signedness: MULH, DIV and REM both signed; MULHSU OPERAND1 signed only; the rest unsigned. The sign fix-up SHALL be applied in the final BUSY cycle.
REQ-016 BUSY SHALL perform an unsigned shift-add multiply (64-bit product) or a restoring divide (32-bit quotient and remainder), with ITER_PER_CYCLE steps per edge; BUSY->DONE SHALL occur after 32/ITER_PER_CYCLE edges.
REQ-017 RESULT selection: MUL = product[31:0]; MULH, MULHSU and MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder. The remainder SHALL take the sign of the dividend.
REQ-018 Divide by zero SHALL bypass iteration (IDLE->DONE on the accept edge): DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> OPERAND1.
REQ-019 Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF) SHALL bypass iteration: DIV -> 0x80000000, REM -> 0.
REQ-020 DONE state SHALL last exactly one cycle with DONE=1, then return to IDLE; no new operation is accepted in the DONE cycle.
REQ-021 STALL SHALL be combinational: (IDLE & VALID & M-op & !FLUSH) | BUSY. STALL SHALL be 0 in DONE so the pipeline captures RESULT.
REQ-022 Timing at ITER_PER_CYCLE=1: STALL high for 33 consecutive cycles (accept cycle + 32 BUSY cycles), then DONE high for 1 cycle.
REQ-023 FLUSH=1 in BUSY SHALL force IDLE on the next edge with no DONE pulse and RESULT unchanged; FLUSH in IDLE SHALL block acceptance.
REQ-024 VALID and ALUOP changes during BUSY SHALL be ignored; operands are taken only from the latched copies.

Reset
REQ-025 RESET=0 SHALL immediately force state IDLE, STALL=0, DONE=0, RESULT=0 and counter=0, regardless of CLK, including mid-operation.
REQ-026 The first edge after RESET deasserts SHALL be able to accept an operation.

Verification
REQ-027 MUL 7 x 0xFFFFFFFD (-3) -> STALL high 33 cycles, then DONE pulse with RESULT=0xFFFFFFEB.
REQ-028 MULH 0x80000000 x 0x80000000 -> RESULT=0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> RESULT=0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> RESULT=0xFFFFFFFF.
REQ-029 DIV 0xFFFFFFF9 (-7) / 2 -> RESULT=0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-030 DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0; each with DONE on the cycle after accept and STALL high for 1 cycle only.
REQ-031 FLUSH at BUSY cycle 10 -> IDLE next edge, STALL=0, no DONE, RESULT unchanged; RESET low at BUSY cycle 5 -> outputs zero immediately, no DONE.
REQ-032 VALID with ALUOP=00001 (ADD) -> STALL=0, no state change; back-to-back M-ops -> second accepted in the cycle after DONE, RESULT updated correctly.
